arp_tx: RTL and testbench

//  Transmit side of the ARP path. Builds complete Ethernet/ARP frames as an 8-bit AXI-Stream.
//  Two frame types: replies to ARP requests addressed to the local IP (trigger comes from the rx parser),
//  and requests for an unresolved destination IP (trigger comes from the IP tx path when the

---
 rtl/arp_pkg.sv | 40 ++++
 rtl/arp_tx.sv | 139 +++++++++++++
 tb/tb_arp_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_pkg.sv
// ARP transmit constants, frame field bundle and the byte mux shared by the ARP tx path.
package arp_pkg;

   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
   localparam logic [7:0]  ARP_HLEN      = 8'h06;
   localparam logic [7:0]  ARP_PLEN      = 8'h04;
   localparam logic [15:0] ARP_OPER_REQ  = 16'h0001;
   localparam logic [15:0] ARP_OPER_REP  = 16'h0002;
   localparam int unsigned ARP_LEN       = 42;
   localparam int unsigned ETH_MIN_LEN   = 60;

   typedef enum logic [1:0] {IDLE, LOAD, SEND} arp_tx_state_t;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [31:0] src_ip;
      logic [15:0] oper;
      logic [47:0] tha;
      logic [31:0] tpa;
   } arp_fields_t;

   // Byte idx of the frame; everything past the ARP payload is zero padding.
   function automatic logic [7:0] arp_byte(input logic [5:0] idx, input arp_fields_t f);
      logic [ARP_LEN*8-1:0] hdr;
      logic [8:0]           pos;
      logic [7:0]           byte_v;
      hdr = {f.dst_mac, f.src_mac, ETH_TYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IP,
             ARP_HLEN, ARP_PLEN, f.oper, f.src_mac, f.src_ip, f.tha, f.tpa};
      byte_v = '0;
      if (32'(idx) < ARP_LEN) begin
         pos    = 9'((ARP_LEN - 1 - 32'(idx)) * 8);
         byte_v = hdr[pos +: 8];
      end
      return byte_v;
   endfunction

endpackage

// File: rtl/arp_tx.sv
// ARP frame transmitter: queues reply/query triggers and streams Ethernet/ARP frames over 8-bit AXI-Stream.
module arp_tx
   import arp_pkg::*;
#(
   parameter bit          PAD_EN  = 1'b1,
   parameter int unsigned REQ_GAP = 1000
) (
   input  logic        clk,
   input  logic        arp_tx_rst,
   input  logic [47:0] local_mac,
   input  logic [31:0] local_ip,
   input  logic        arp_reply_req,
   input  logic [47:0] arp_reply_mac,
   input  logic [31:0] arp_reply_ip,
   input  logic        arp_query_req,
   input  logic [31:0] arp_query_ip,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        arp_tx_busy,
   output logic        arp_tx_done,
   output logic        arp_tx_drop
);

   localparam logic [5:0] LAST_IDX = PAD_EN ? 6'(ETH_MIN_LEN - 1) : 6'(ARP_LEN - 1);

   arp_tx_state_t state;
   logic          reply_pend, query_pend;
   logic [47:0]   reply_mac;
   logic [31:0]   reply_ip, query_ip;
   logic [31:0]   last_query_ip, gap_cnt;
   arp_fields_t   frame, load_fields;
   logic [5:0]    byte_cnt;
   logic          load_reply, load_query;
   logic          query_dup, query_take, reply_ovr, query_ovr;

   always_comb begin
      load_reply = (state == LOAD) && reply_pend;
      load_query = (state == LOAD) && !reply_pend && query_pend;
      // A query for the IP being loaded right now counts as a repeat of it.
      query_dup  = arp_query_req &&
                   (((arp_query_ip == last_query_ip) && (gap_cnt < REQ_GAP)) ||
                    (load_query && (arp_query_ip == query_ip)));
      query_take = arp_query_req && !query_dup;
      reply_ovr  = arp_reply_req && reply_pend && !load_reply;
      query_ovr  = query_take && query_pend && !load_query;

      load_fields         = '0;
      load_fields.src_mac = local_mac;
      load_fields.src_ip  = local_ip;
      if (reply_pend) begin
         load_fields.dst_mac = reply_mac;
         load_fields.oper    = ARP_OPER_REP;
         load_fields.tha     = reply_mac;
         load_fields.tpa     = reply_ip;
      end else begin
         load_fields.dst_mac = '1;
         load_fields.oper    = ARP_OPER_REQ;
         load_fields.tha     = '0;
         load_fields.tpa     = query_ip;
      end
   end

   assign arp_tx_busy = (state != IDLE);

   always_ff @(posedge clk or posedge arp_tx_rst) begin
      if (arp_tx_rst) begin
         state         <= IDLE;
         reply_pend    <= 1'b0;
         query_pend    <= 1'b0;
         reply_mac     <= '0;
         reply_ip      <= '0;
         query_ip      <= '0;
         last_query_ip <= '0;
         gap_cnt       <= '1;
         frame         <= '0;
         byte_cnt      <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         arp_tx_done   <= 1'b0;
         arp_tx_drop   <= 1'b0;
      end else begin
         arp_tx_done <= 1'b0;
         arp_tx_drop <= reply_ovr || query_ovr || query_dup;
         if (gap_cnt != '1) gap_cnt <= gap_cnt + 32'd1;

         case (state)
            IDLE: begin
               if (reply_pend || query_pend) state <= LOAD;
            end
            LOAD: begin
               frame         <= load_fields;
               byte_cnt      <= '0;
               m_axis_tdata  <= arp_byte(6'd0, load_fields);
               m_axis_tlast  <= (LAST_IDX == 6'd0);
               m_axis_tvalid <= 1'b1;
               state         <= SEND;
               if (reply_pend) begin
                  reply_pend <= 1'b0;
               end else begin
                  query_pend    <= 1'b0;
                  last_query_ip <= query_ip;
                  gap_cnt       <= '0;
               end
            end
            SEND: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (m_axis_tlast) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     m_axis_tdata  <= '0;
                     arp_tx_done   <= 1'b1;
                     state         <= IDLE;
                  end else begin
                     byte_cnt     <= byte_cnt + 6'd1;
                     m_axis_tdata <= arp_byte(byte_cnt + 6'd1, frame);
                     m_axis_tlast <= ((byte_cnt + 6'd1) == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Captures come last so a pulse coinciding with LOAD re-arms the flag.
         if (arp_reply_req) begin
            reply_pend <= 1'b1;
            reply_mac  <= arp_reply_mac;
            reply_ip   <= arp_reply_ip;
         end
         if (query_take) begin
            query_pend <= 1'b1;
            query_ip   <= arp_query_ip;
         end
      end
   end

endmodule

// File: tb/tb_arp_tx.sv
// Scoreboard bench for arp_tx: padded instance (u_pad) and unpadded instance (u_nopad).
module tb_arp_tx;

   localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
   localparam logic [31:0] LIP  = 32'hC0_A8_01_0A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0 = 1'b1, rst1 = 1'b1;
   logic        rreq0 = 1'b0, rreq1 = 1'b0, qreq0 = 1'b0, qreq1 = 1'b0;
   logic [47:0] rmac = '0;
   logic [31:0] rip = '0, qip = '0;
   logic        rdy0 = 1'b1, rdy1 = 1'b1;
   logic        rand_rdy = 1'b0;

   logic [7:0]  tdata0, tdata1;
   logic        tvalid0, tvalid1, tlast0, tlast1;
   logic        busy0, busy1, done0, done1, drop0, drop1;

   arp_tx #(.PAD_EN(1'b1), .REQ_GAP(200)) u_pad (
      .clk(clk), .arp_tx_rst(rst0), .local_mac(LMAC), .local_ip(LIP),
      .arp_reply_req(rreq0), .arp_reply_mac(rmac), .arp_reply_ip(rip),
      .arp_query_req(qreq0), .arp_query_ip(qip),
      .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(rdy0), .m_axis_tlast(tlast0),
      .arp_tx_busy(busy0), .arp_tx_done(done0), .arp_tx_drop(drop0));

   arp_tx #(.PAD_EN(1'b0), .REQ_GAP(200)) u_nopad (
      .clk(clk), .arp_tx_rst(rst1), .local_mac(LMAC), .local_ip(LIP),
      .arp_reply_req(rreq1), .arp_reply_mac(rmac), .arp_reply_ip(rip),
      .arp_query_req(qreq1), .arp_query_ip(qip),
      .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(rdy1), .m_axis_tlast(tlast1),
      .arp_tx_busy(busy1), .arp_tx_done(done1), .arp_tx_drop(drop1));

   int n_vec = 0, n_fail = 0;
   logic [8:0] q0[$], q1[$];
   int   done_c[2], drop_c[2], lowrun[2];
   bit   seen[2], pstall[2];
   logic pv[2], plast[2];
   logic [7:0] pdata[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int d, input logic [47:0] dst, input logic [15:0] oper,
                             input logic [47:0] tha, input logic [31:0] tpa, input bit pad);
      logic [7:0] b[60];
      int n;
      for (int i = 0; i < 60; i++) b[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         b[i]    = 8'(dst  >> (40 - 8 * i));
         b[6+i]  = 8'(LMAC >> (40 - 8 * i));
         b[22+i] = 8'(LMAC >> (40 - 8 * i));
         b[32+i] = 8'(tha  >> (40 - 8 * i));
      end
      b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
      b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
      b[20] = oper[15:8]; b[21] = oper[7:0];
      for (int i = 0; i < 4; i++) begin
         b[28+i] = 8'(LIP >> (24 - 8 * i));
         b[38+i] = 8'(tpa >> (24 - 8 * i));
      end
      n = pad ? 60 : 42;
      for (int i = 0; i < n; i++) begin
         if (d == 0) q0.push_back({(i == n - 1), b[i]});
         else        q1.push_back({(i == n - 1), b[i]});
      end
   endtask

   task automatic mon(input int d, input logic v, input logic r, input logic [7:0] data,
                      input logic last, input logic dn, input logic dr);
      logic [8:0] e;
      bit         have;
      if (dn) done_c[d]++;
      if (dr) drop_c[d]++;
      if (v) begin
         if (!pv[d] && seen[d]) chk(d == 0 ? "gap0" : "gap1", 32'(lowrun[d] >= 2), 32'd1);
         if (pstall[d]) chk(d == 0 ? "hold0" : "hold1", 32'({last, data}), 32'({plast[d], pdata[d]}));
         lowrun[d] = 0;
         seen[d]   = 1'b1;
         if (r) begin
            have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
               n_vec++; n_fail++;
               $display("FAIL unexpected_byte d%0d: got %0h expected none", d, {last, data});
            end else begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               chk(d == 0 ? "byte0" : "byte1", 32'({last, data}), 32'(e));
            end
         end
      end else begin
         lowrun[d]++;
      end
      pstall[d] = v && !r;
      pdata[d]  = data;
      plast[d]  = last;
      pv[d]     = v;
   endtask

   always @(negedge clk) begin
      #2;
      mon(0, tvalid0, rdy0, tdata0, tlast0, done0, drop0);
      mon(1, tvalid1, rdy1, tdata1, tlast1, done1, drop1);
   end

   always @(negedge clk) if (rand_rdy) rdy0 = 1'($urandom_range(0, 1));

   task automatic pulse_reply(input int d, input logic [47:0] mac, input logic [31:0] ip);
      @(negedge clk);
      rmac = mac; rip = ip;
      if (d == 0) rreq0 = 1'b1; else rreq1 = 1'b1;
      @(negedge clk);
      rreq0 = 1'b0; rreq1 = 1'b0;
   endtask

   task automatic pulse_query(input int d, input logic [31:0] ip);
      @(negedge clk);
      qip = ip;
      if (d == 0) qreq0 = 1'b1; else qreq1 = 1'b1;
      @(negedge clk);
      qreq0 = 1'b0; qreq1 = 1'b0;
   endtask

   task automatic wait_done(input int d, input int target, input int budget);
      int i = 0;
      while (done_c[d] < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      @(negedge clk);
      chk(d == 0 ? "done_cnt0" : "done_cnt1", 32'(done_c[d]), 32'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, i;
      for (int k = 0; k < 2; k++) begin
         done_c[k] = 0; drop_c[k] = 0; lowrun[k] = 0;
         seen[k] = 1'b0; pstall[k] = 1'b0; pv[k] = 1'b0; plast[k] = 1'b0; pdata[k] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_tvalid0", 32'(tvalid0), 0); chk("rst_tlast0", 32'(tlast0), 0);
      chk("rst_busy0", 32'(busy0), 0);     chk("rst_done0", 32'(done0), 0);
      chk("rst_drop0", 32'(drop0), 0);     chk("rst_tdata0", 32'(tdata0), 0);
      chk("rst_tvalid1", 32'(tvalid1), 0); chk("rst_busy1", 32'(busy1), 0);
      rst0 = 1'b0; rst1 = 1'b0;
      repeat (2) @(negedge clk);

      // 1: reply, latency N+3
      push_frame(0, 48'h00_11_22_33_44_55, 16'h0002, 48'h00_11_22_33_44_55, 32'hC0_A8_01_14, 1);
      pulse_reply(0, 48'h00_11_22_33_44_55, 32'hC0_A8_01_14);
      chk("lat_n1_tvalid", 32'(tvalid0), 0); chk("lat_n1_busy", 32'(busy0), 0);
      @(negedge clk);
      chk("lat_n2_tvalid", 32'(tvalid0), 0); chk("lat_n2_busy", 32'(busy0), 1);
      @(negedge clk);
      chk("lat_n3_tvalid", 32'(tvalid0), 1); chk("lat_n3_tdata", 32'(tdata0), 32'h00);
      wait_done(0, 1, 200);

      // 2: query then dedupe inside REQ_GAP, then accepted after it
      push_frame(0, '1, 16'h0001, '0, 32'h0A_00_00_05, 1);
      pulse_query(0, 32'h0A_00_00_05);
      wait_done(0, 2, 200);
      pulse_query(0, 32'h0A_00_00_05);
      chk("dup_drop", 32'(drop0), 1);
      repeat (10) @(negedge clk);
      chk("dup_no_frame", 32'(busy0), 0);
      repeat (200) @(negedge clk);
      push_frame(0, '1, 16'h0001, '0, 32'h0A_00_00_05, 1);
      pulse_query(0, 32'h0A_00_00_05);
      chk("gap_expired_drop", 32'(drop0), 0);
      wait_done(0, 3, 200);

      // 3: simultaneous reply + query
      push_frame(0, 48'hAA_BB_CC_DD_EE_FF, 16'h0002, 48'hAA_BB_CC_DD_EE_FF, 32'hC0_A8_01_1E, 1);
      push_frame(0, '1, 16'h0001, '0, 32'h0A_00_00_07, 1);
      @(negedge clk);
      rmac = 48'hAA_BB_CC_DD_EE_FF; rip = 32'hC0_A8_01_1E; qip = 32'h0A_00_00_07;
      rreq0 = 1'b1; qreq0 = 1'b1;
      @(negedge clk);
      rreq0 = 1'b0; qreq0 = 1'b0;
      chk("both_drop", 32'(drop0), 0);
      wait_done(0, 5, 400);

      // 4: random backpressure
      push_frame(0, 48'h00_DE_AD_BE_EF_01, 16'h0002, 48'h00_DE_AD_BE_EF_01, 32'hC0_A8_01_33, 1);
      rand_rdy = 1'b1;
      pulse_reply(0, 48'h00_DE_AD_BE_EF_01, 32'hC0_A8_01_33);
      wait_done(0, 6, 1000);
      rand_rdy = 1'b0;
      @(negedge clk);
      rdy0 = 1'b1;

      // 5: reset at byte 30, pending reply lost, new query sent whole
      push_frame(0, '1, 16'h0001, '0, 32'h0A_00_00_09, 1);
      pulse_query(0, 32'h0A_00_00_09);
      n = 0; i = 0;
      while (i < 300) begin
         @(negedge clk);
         i++;
         rreq0 = 1'b0;
         if (tvalid0) begin
            if (n == 30) break;
            if (n == 10) begin
               rmac = 48'h00_00_00_00_0B_AD; rip = 32'hC0_A8_01_63; rreq0 = 1'b1;
            end
            n++;
         end
      end
      chk("reach_byte30", 32'(n), 32'd30);
      chk("byte30_data", 32'(tdata0), 32'h01);
      rst0 = 1'b1;
      #1;
      chk("rst_mid_tvalid", 32'(tvalid0), 0);
      chk("rst_mid_busy", 32'(busy0), 0);
      chk("rst_mid_tlast", 32'(tlast0), 0);
      q0.delete();
      repeat (2) @(negedge clk);
      rst0 = 1'b0;
      repeat (6) @(negedge clk);
      chk("pend_lost", 32'(busy0), 0);
      push_frame(0, '1, 16'h0001, '0, 32'h0A_00_00_09, 1);
      pulse_query(0, 32'h0A_00_00_09);
      chk("post_rst_drop", 32'(drop0), 0);
      wait_done(0, 7, 200);

      // 6: unpadded instance, second reply queued during SEND
      push_frame(1, 48'h02_AA_BB_CC_DD_01, 16'h0002, 48'h02_AA_BB_CC_DD_01, 32'hC0_A8_01_40, 0);
      push_frame(1, 48'h02_AA_BB_CC_DD_02, 16'h0002, 48'h02_AA_BB_CC_DD_02, 32'hC0_A8_01_41, 0);
      pulse_reply(1, 48'h02_AA_BB_CC_DD_01, 32'hC0_A8_01_40);
      n = 0; i = 0;
      while (i < 100 && n < 6) begin
         @(negedge clk);
         i++;
         rreq1 = 1'b0;
         if (tvalid1) begin
            if (n == 5) begin
               rmac = 48'h02_AA_BB_CC_DD_02; rip = 32'hC0_A8_01_41; rreq1 = 1'b1;
            end
            n++;
         end
      end
      @(negedge clk);
      rreq1 = 1'b0;
      wait_done(1, 2, 400);

      repeat (5) @(negedge clk);
      chk("q0_empty", 32'(q0.size()), 0);
      chk("q1_empty", 32'(q1.size()), 0);
      chk("drop_cnt0", 32'(drop_c[0]), 1);
      chk("drop_cnt1", 32'(drop_c[1]), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
